// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with start/busy/done handshake, signed/unsigned modes.
// Optional DIV_EARLY_OUT_EN: trivial cases (B==0, |A|<|B|) complete one cycle after start.
module seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sign,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     A,
  input  logic [DATA_WIDTH-1:0]     B,
  output logic                      busy,
  output logic                      done,
  output logic                      div_by_zero,
  output logic [2*DATA_WIDTH-1:0]   C
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [W:0]      rem;
  logic [W-1:0]    quo;
  logic [W-1:0]    bmag;
  logic [W-1:0]    araw;
  logic [CW-1:0]   cnt;
  logic            neg_q;
  logic            neg_r;
  logic            bzero;

  logic [W-1:0]    a_mag_in;
  logic [W-1:0]    b_mag_in;
  logic [W+1:0]    rem_sh;
  logic [W+1:0]    trial;
  logic [W-1:0]    q_fix;
  logic [W-1:0]    r_fix;

  assign a_mag_in = (sign && A[W-1]) ? -A : A;
  assign b_mag_in = (sign && B[W-1]) ? -B : B;

  // Shifted partial remainder; top bit of trial is the borrow that decides restore.
  assign rem_sh = {rem, quo[W-1]};
  assign trial  = rem_sh - {2'b00, bmag};

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem[W-1:0] : rem[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      C           <= '0;
      rem         <= '0;
      quo         <= '0;
      bmag        <= '0;
      araw        <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      bzero       <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_by_zero <= 1'b0;
            neg_q       <= sign && (A[W-1] ^ B[W-1]);
            neg_r       <= sign && A[W-1];
            araw        <= A;
            bzero       <= (B == '0);
            rem         <= '0;
            quo         <= a_mag_in;
            bmag        <= b_mag_in;
            cnt         <= CW'(W);
`ifdef DIV_EARLY_OUT_EN
            if (B == '0) begin
              C           <= {A, {W{1'b1}}};
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else if (a_mag_in < b_mag_in) begin
              C     <= {A, {W{1'b0}}};
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
`else
            busy  <= 1'b1;
            state <= CALC;
`endif
          end
        end
        CALC: begin
          rem <= trial[W+1] ? rem_sh[W:0] : trial[W:0];
          quo <= {quo[W-2:0], ~trial[W+1]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (bzero) begin
            C           <= {araw, {W{1'b1}}};
            div_by_zero <= 1'b1;
          end else begin
            C <= {r_fix, q_fix};
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_seq_divider;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sign = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [2*W-1:0] C;

  int ntests = 0;
  int nfail  = 0;

  seq_divider #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .flush(flush),
    .A(A), .B(B), .busy(busy), .done(done), .div_by_zero(div_by_zero), .C(C)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic longint mag(input logic [31:0] v, input logic s);
    longint t;
    if (s) t = longint'($signed(v));
    else   t = longint'({32'b0, v});
    return (t < 0) ? -t : t;
  endfunction

  // Reference result {remainder, quotient} from plain integer arithmetic.
  function automatic logic [63:0] ref_c(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    logic [63:0] q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = {32'b0, a / b};
      r = {32'b0, a % b};
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic bit trivial(input logic [31:0] a, input logic [31:0] b, input logic s);
    return (b == 0) || (mag(a, s) < mag(b, s));
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    return (EARLY && trivial(a, b, s)) ? 1 : W + 2;
  endfunction

  // Transaction model: remaining busy cycles counted down per accepted operation.
  bit          m_act = 1'b0;
  bit          m_done = 1'b0;
  bit          m_dbz = 1'b0;
  int          m_left = 0;
  logic [63:0] m_c = '0;
  logic [63:0] p_c = '0;
  bit          p_dz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0; m_left <= 0; m_c <= '0;
    end else if (flush) begin
      m_act <= 1'b0; m_done <= 1'b0;
    end else if (m_act) begin
      if (m_left == 1) begin
        m_act <= 1'b0; m_done <= 1'b1; m_c <= p_c; m_dbz <= p_dz;
      end
      m_left <= m_left - 1;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (start) begin
      m_dbz <= 1'b0;
      if (EARLY && trivial(A, B, sign)) begin
        m_done <= 1'b1; m_c <= ref_c(A, B, sign); m_dbz <= (B == 0);
      end else begin
        m_act <= 1'b1; m_left <= W + 1; p_c <= ref_c(A, B, sign); p_dz <= (B == 0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("cmp_busy", busy, m_act);
    check("cmp_done", done, m_done);
    check("cmp_C", C, m_c);
    check("cmp_dz", div_by_zero, m_dbz);
  end

  task automatic begin_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; sign = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom; sign = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int lat0, output int lat, output int busy_n);
    lat = lat0;
    busy_n = 0;
    while (!done && lat < 200) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      ntests++;
      nfail++;
      $display("FAIL wait_done: no done within %0d cycles", lat);
    end
  endtask

  task automatic dir(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [63:0] ec, input logic edz, output int lat, output int bn);
    begin_op(a, b, s);
    wait_done(1, lat, bn);
    check({nm, "_C"}, C, ec);
    check({nm, "_dz"}, div_by_zero, edz);
    check({nm, "_lat"}, lat, exp_lat(a, b, s));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, bn, ndone;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_C", C, 0);
    rst = 1'b0;

    dir("u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b0, lat, bn);
    check("u100_7_latency", lat, 34);
    check("u100_7_busy_cycles", bn, 33);

    dir("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b0, lat, bn);
    dir("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 1'b0, lat, bn);

    dir("u5_0", 32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF, 1'b1, lat, bn);
    dir("s5_0", 32'd5, 32'd0, 1'b1, 64'h00000005_FFFFFFFF, 1'b1, lat, bn);
    dir("u5_3_clr", 32'd5, 32'd3, 1'b0, 64'h00000002_00000001, 1'b0, lat, bn);

    dir("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 1'b0, lat, bn);
    dir("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h80000000_00000000, 1'b0, lat, bn);

    dir("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 1'b0, lat, bn);
    dir("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h00000000_00000001, 1'b0, lat, bn);
    dir("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 64'hFFFFFFFE_FFFFFFF2, 1'b0, lat, bn);
    dir("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 64'hFFFFFFFE_0000000E, 1'b0, lat, bn);
    dir("s_0_5", 32'd0, 32'd5, 1'b1, 64'h00000000_00000000, 1'b0, lat, bn);
    dir("u_1e6_1e3", 32'd1000000, 32'd1000, 1'b0, 64'h00000000_000003E8, 1'b0, lat, bn);
    dir("s_maxpos_2", 32'h7FFF_FFFF, 32'd2, 1'b1, 64'h00000001_3FFFFFFF, 1'b0, lat, bn);

    // flush at cycle 10 aborts; C keeps the previous result
    begin_op(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("flush_no_done", ndone, 0);
    check("flush_C_held", C, 64'h00000001_3FFFFFFF);

    // start while busy is dropped
    begin_op(32'd50, 32'd5, 1'b0);
    repeat (3) @(negedge clk);
    A = 32'd9; B = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat, bn);
    check("ignored_start_C", C, 64'h00000000_0000000A);
    check("ignored_start_lat", lat, 34);

    // asynchronous reset mid-CALC
    begin_op(32'd1000, 32'd3, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_dz", div_by_zero, 0);
    check("async_rst_C", C, 0);
    @(negedge clk);
    rst = 1'b0;

    dir("u3_9", 32'd3, 32'd9, 1'b0, 64'h00000003_00000000, 1'b0, lat, bn);
    check("u3_9_busy_cycles", bn, EARLY ? 0 : 33);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
